isqrt_share_arbiter: RTL
========================

# isqrt_share_arbiter

Round-robin arbiter that lets several normalization pipelines share one `fixed_isqrt` instance. Each pipeline produces a variance only once per group, so one isqrt unit is enough for all of them. The arbiter grants one variance request per cycle to the shared unit and records the requester's index in an in-order tag FIFO. It then routes each isqrt result back to the requester that issued it. The block sits between the per-lane `variance_reg` skid buffers and the per-lane `single_element_repeat` isqrt buffers. The shared `fixed_isqrt` is instantiated outside this block.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting norm lanes; must be ≥2.
- `DATA_WIDTH`, 16: width of the variance and of the isqrt result; equals `ISQRT_WIDTH` of the lanes.
- `MAX_INFLIGHT`, 4: depth of the tag FIFO; must be ≥ the isqrt pipeline depth for full throughput.
- `TAG_WIDTH`, `$clog2(NUM_REQ)`: derived parameter; do not override.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_data`, in, `[DATA_WIDTH-1:0] x [NUM_REQ-1:0]` (unpacked): variance from each lane.
- `req_valid`, in, `NUM_REQ`: request valid, one bit per lane.
- `req_ready`, out, `NUM_REQ`: request accepted, one-hot or zero.
- `unit_in_data`, out, `DATA_WIDTH`: to the shared isqrt `in_data`.
- `unit_in_valid`, out, 1: to isqrt `in_valid`.
- `unit_in_ready`, in, 1: from isqrt `in_ready`.
- `unit_out_data`, in, `DATA_WIDTH`: from isqrt `out_data`.
- `unit_out_valid`, in, 1: from isqrt `out_valid`.
- `unit_out_ready`, out, 1: to isqrt `out_ready`.
- `resp_data`, out, `DATA_WIDTH`: result, broadcast to all lanes.
- `resp_valid`, out, `NUM_REQ`: one-hot result valid.
- `resp_ready`, in, `NUM_REQ`: per-lane result ready.
- `inflight`, out, `$clog2(MAX_INFLIGHT+1)`: current tag FIFO occupancy.
- `err`, out, 1: sticky protocol error flag.

## Operation
Grant:
- `eligible = req_valid` when the tag FIFO is not full; `eligible = 0` when it is full.
- When no grant is locked, `gnt` is the first set bit of `eligible`, searching circularly from `rr_ptr`.
- `unit_in_valid = |gnt`.
- `unit_in_data = req_data[gnt_idx]`.
- `req_ready = gnt & {NUM_REQ{unit_in_ready}}`.

Lock:
- If `unit_in_valid && !unit_in_ready`, register `lock_valid=1` and `lock_idx=gnt_idx`.
- While locked, `gnt` is forced to `lock_idx`, regardless of the other requesters or `rr_ptr`.
- The lock clears on the accepting handshake.
- This holds the valid/ready contract toward the isqrt unit: the data shown to it does not change while it is stalled.

Accept (`unit_in_valid && unit_in_ready`):
- Push `gnt_idx` into the tag FIFO.
- `rr_ptr <= (gnt_idx+1) mod NUM_REQ`.

Return path:
- `resp_data = unit_out_data`.
- `resp_valid = tag FIFO nonempty && unit_out_valid`, one-hot at `head_tag`.
- `unit_out_ready = nonempty && resp_ready[head_tag]`.
- Pop the tag FIFO on `unit_out_valid && unit_out_ready`.
- The isqrt unit is in-order; this block relies on that and does no reordering.

FIFO boundary conditions:
- Full: `eligible=0`, so no new grant starts.
- Full with a lock already set: `unit_in_valid` is still driven, so the handshake can complete. The lock can only be set if the FIFO had room when the grant was issued.
- Push and pop in the same cycle: both take effect, and occupancy is unchanged.
- Full with a pop this cycle: the push is still blocked this cycle. Full is evaluated on the registered occupancy.
- Pointer wrap: `rr_ptr` and the FIFO pointers wrap modulo their size.

Error:
- `err` sets and stays set when `unit_out_valid` is high while the tag FIFO is empty.
- In that state `unit_out_ready` stays 0, so the stray result is not consumed.

## Timing
- Request → `unit_in_valid`: combinational, 0 cycles.
- `unit_out_valid` → `resp_valid`: combinational, 0 cycles.
- Registered state: `rr_ptr`, lock, tag FIFO, `err`.
- Throughput: one grant per cycle while the FIFO has room and `unit_in_ready=1`.
- Reset (synchronous, `rst=1` at a clock edge), all registers clear:
  - `rr_ptr=0`, lock cleared, FIFO empty, `inflight=0`, `err=0`.
  - So after reset `req_ready=0`, `resp_valid=0`, `unit_out_ready=0`; `unit_in_valid=0` unless a request is valid.
- Reset mid-operation discards all in-flight tags. The shared isqrt and all lanes must be reset by the same `rst`.

## Test plan
1. **Single requester.** Lane 2 requests `0x0100`; isqrt latency is 3.
   - Expect `unit_in_data=0x0100` with `req_ready=4'b0100` in cycle 0.
   - Expect `resp_valid=4'b0100` 3 cycles later, `inflight` 1 → 0.
2. **Fairness.** All 4 lanes hold valid continuously; the unit is always ready.
   - Expect grant order 0,1,2,3,0,…
   - Expect `resp_valid` order identical.
3. **Stall lock.** Lanes 1 and 3 are valid; `unit_in_ready=0` for 5 cycles.
   - Expect `unit_in_data` to stay at lane 1's value for all 5 cycles.
   - When ready rises, expect lane 1 to be accepted, then lane 3.
4. **FIFO full.** `MAX_INFLIGHT=4`; `unit_out_ready` is blocked by holding all `resp_ready=0`.
   - After 4 accepts expect `inflight=4` and `unit_in_valid=0`.
   - Release lane 0 `resp_ready`: expect 1 pop, then a new grant the next cycle.
5. **Response backpressure.** The head result is for lane 1 with `resp_ready[1]=0`.
   - Expect `unit_out_ready=0` until it is asserted; other lanes' results wait behind it.
6. **Error and reset.** Drive `unit_out_valid=1` with the FIFO empty.
   - Expect `err=1` and it stays set.
   - Assert `rst` with 2 tags in flight: expect `err=0`, `inflight=0` and `rr_ptr=0` the next cycle.

Source files
------------

// File: rtl/isqrt_share_arbiter_if.sv
// Handshake bundle between the norm lanes, the shared isqrt unit and isqrt_share_arbiter.
// The arbiter connects through the slave modport; the lane/unit side uses master.
interface isqrt_share_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ-1:0];
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [DATA_WIDTH-1:0] unit_in_data;
    logic                  unit_in_valid;
    logic                  unit_in_ready;
    logic [DATA_WIDTH-1:0] unit_out_data;
    logic                  unit_out_valid;
    logic                  unit_out_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;

    modport master (
        output req_data,
        output req_valid,
        input  req_ready,
        input  unit_in_data,
        input  unit_in_valid,
        output unit_in_ready,
        output unit_out_data,
        output unit_out_valid,
        input  unit_out_ready,
        input  resp_data,
        input  resp_valid,
        output resp_ready
    );

    modport slave (
        input  req_data,
        input  req_valid,
        output req_ready,
        output unit_in_data,
        output unit_in_valid,
        input  unit_in_ready,
        input  unit_out_data,
        input  unit_out_valid,
        output unit_out_ready,
        output resp_data,
        output resp_valid,
        input  resp_ready
    );
endinterface

// File: rtl/isqrt_share_arbiter.sv
// Round-robin share of one in-order isqrt unit among NUM_REQ norm lanes; an in-order
// tag FIFO remembers which lane issued each accepted request so results route back.
module isqrt_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_INFLIGHT = 4,
    parameter int TAG_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    isqrt_share_arbiter_if.slave              bus,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              err
);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(MAX_INFLIGHT - 1);
    localparam logic [TAG_WIDTH-1:0] TAG_LAST = TAG_WIDTH'(NUM_REQ - 1);

    logic [TAG_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 lock_valid_q, lock_valid_d;
    logic [TAG_WIDTH-1:0] lock_idx_q, lock_idx_d;
    logic [TAG_WIDTH-1:0] tag_mem_q [MAX_INFLIGHT];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 err_q, err_d;

    logic                 full_s;
    logic                 nonempty_s;
    logic [NUM_REQ-1:0]   eligible_s;
    logic                 pick_valid_s;
    logic [TAG_WIDTH-1:0] pick_idx_s;
    logic                 gnt_valid_s;
    logic [TAG_WIDTH-1:0] gnt_idx_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [TAG_WIDTH-1:0] head_tag_s;
    logic                 accept_s;
    logic                 pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = '0;
        end else begin
            n = p + 1'b1;
        end
        return n;
    endfunction

    function automatic logic [TAG_WIDTH-1:0] tag_inc(input logic [TAG_WIDTH-1:0] t);
        logic [TAG_WIDTH-1:0] n;
        if (t == TAG_LAST) begin
            n = '0;
        end else begin
            n = t + 1'b1;
        end
        return n;
    endfunction

    // First set bit of elig, scanning circularly from start; MSB of result is "found".
    function automatic logic [TAG_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0]   elig,
                                                   input logic [TAG_WIDTH-1:0] start);
        logic [TAG_WIDTH:0]   res;
        logic [TAG_WIDTH-1:0] idx;
        res = '0;
        idx = start;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!res[TAG_WIDTH] && elig[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
            idx = tag_inc(idx);
        end
        return res;
    endfunction

    assign full_s     = (count_q == FULL_CNT);
    assign nonempty_s = (count_q != '0);
    assign head_tag_s = tag_mem_q[rd_ptr_q];

    // Grant selection: a stalled grant is pinned so the unit sees stable data.
    always_comb begin
        eligible_s                 = full_s ? '0 : bus.req_valid;
        {pick_valid_s, pick_idx_s} = rr_pick(eligible_s, rr_ptr_q);
        if (lock_valid_q) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = lock_idx_q;
        end else begin
            gnt_valid_s = pick_valid_s;
            gnt_idx_s   = pick_idx_s;
        end
        gnt_s = gnt_valid_s ? (NUM_REQ'(1'b1) << gnt_idx_s) : '0;
    end

    assign accept_s = gnt_valid_s & bus.unit_in_ready;
    assign pop_s    = bus.unit_out_valid & bus.unit_out_ready;

    assign bus.unit_in_valid  = gnt_valid_s;
    assign bus.unit_in_data   = bus.req_data[gnt_idx_s];
    assign bus.req_ready      = gnt_s & {NUM_REQ{bus.unit_in_ready}};
    assign bus.resp_data      = bus.unit_out_data;
    assign bus.unit_out_ready = nonempty_s & bus.resp_ready[head_tag_s];

    // Result routing: only a result with a matching tag is presented to a lane.
    always_comb begin
        if (nonempty_s && bus.unit_out_valid) begin
            bus.resp_valid = NUM_REQ'(1'b1) << head_tag_s;
        end else begin
            bus.resp_valid = '0;
        end
    end

    assign inflight = count_q;
    assign err      = err_q;

    // Next-state for rotation pointer, lock, FIFO pointers/occupancy and error flag.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_d        = err_q | (bus.unit_out_valid & ~nonempty_s);

        if (accept_s) begin
            rr_ptr_d     = tag_inc(gnt_idx_s);
            lock_valid_d = 1'b0;
            wr_ptr_d     = ptr_inc(wr_ptr_q);
        end else if (gnt_valid_s) begin
            lock_valid_d = 1'b1;
            lock_idx_d   = gnt_idx_s;
        end else begin
            lock_valid_d = lock_valid_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

    // Tag storage, written with the granted lane index on each accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else if (accept_s) begin
            tag_mem_q[wr_ptr_q] <= gnt_idx_s;
        end else begin
            tag_mem_q[wr_ptr_q] <= tag_mem_q[wr_ptr_q];
        end
    end
endmodule
